uart_rx_data_sampler: RTL and testbench
=======================================

# uart_rx_data_sampler

Oversampling bit sampler at the front of the UART receiver. Counts oversampling clock edges within each bit period and samples the serial line at the three edges around mid-bit. Resolves the bit by 2-of-3 majority and presents it with a one-cycle valid pulse to the downstream receiver datapath (start/parity/stop checks and bit selection). Also flags the end of each bit period so the bit-index logic can advance.

## Interface
Parameters:
- PRESCALE_WIDTH, 6, width of the prescale input and edge counter.

Ports:
- clk  in  1  receiver clock (oversampling clock).
- reset  in  1  synchronous, active-high reset.
- enable  in  1  sampling enabled; low holds the block idle.
- serial_data  in  1  raw RX line, idle level 1.
- prescale  in  PRESCALE_WIDTH  oversampling ratio (clocks per bit). Legal values are even and ≥4.
- sampled_bit  out  1  majority-voted bit value.
- sample_valid  out  1  one-cycle pulse; sampled_bit updated this cycle.
- bit_done  out  1  one-cycle pulse at end of bit period.
- edge_count  out  PRESCALE_WIDTH  current edge index within bit, 0..prescale-1.
- prescale_error  out  1  prescale currently illegal.

## Operation
- Reset values: sampled_bit=1, sample_valid=0, bit_done=0, edge_count=0, prescale_error=0, sample registers s0/s1/s2=1.
- Taps: T0=prescale/2-1, T1=prescale/2, T2=prescale/2+1.
- enable low: edge_count forced to 0 on next edge. s0..s2 are not cleared. sample_valid and bit_done stay 0, except a pulse already scheduled by a T2 capture in the previous cycle.
- enable high, prescale legal:
  - edge_count increments each cycle and wraps prescale-1 → 0.
  - When edge_count equals Tk, serial_data of that cycle is captured into sk.
- The cycle after edge_count==T2 was sampled with enable high:
  - sampled_bit = (s0&s1)|(s0&s2)|(s1&s2), evaluated with s2 being the value just captured.
  - sample_valid=1 for that cycle.
- The cycle after edge_count==prescale-1 was sampled with enable high: bit_done=1. edge_count is 0 in that same cycle.
- prescale illegal (odd or <4): prescale_error=1 (registered, one cycle after prescale changes). edge_count is held at 0 and no taps, sample_valid or bit_done occur.
- prescale changed mid-bit to a legal value: new taps apply immediately. If edge_count ≥ the new prescale, it wraps to 0 on the next edge without asserting bit_done.
- Reset mid-bit: all registers return to reset values on that edge, and any pending pulse is dropped.
- Majority evaluation is a pure 3-input vote with no tie case.

## Timing
- Latency, serial_data to sampled_bit: 1 cycle after the T2 capture (2 cycles after T2 with DATA_SAMPLER_SYNC_EN).
- edge_count is a register output, valid in the same cycle the counter holds the index.
- sample_valid and bit_done are registered and never high for more than one consecutive cycle.
- With prescale=4 (T2=3=prescale-1), sample_valid and bit_done assert in the same cycle.
- The first enabled cycle has edge_count=0. T0 is reached prescale/2-1 cycles after enable rises.

## Configuration
- DATA_SAMPLER_SYNC_EN:
  - Defined: serial_data passes through a two-flop synchronizer (reset value 1) before tap capture. Tap alignment relative to the pin is delayed by 2 cycles, and edge_count is unaffected.
  - Undefined: serial_data is captured directly. The caller guarantees it is already synchronous to clk.

## Structure
- Shared package uart_rx_pkg:
  - PRESCALE_WIDTH default.
  - UART_IDLE_LEVEL constant (1'b1).
  - Function computing tap indices from prescale.
  - Function checking prescale legality.
- One sub-module: uart_rx_majority3 (combinational 3-input majority), instantiated once.
- Counter, tap capture, synchronizer and pulse generation live in the top module.

## Test plan
- prescale=8, serial_data=1 constant, enable=1:
  - Taps at edges 3,4,5.
  - sample_valid pulses the cycle after edge_count=5 with sampled_bit=1.
  - bit_done the cycle after edge 7, with edge_count=0 that cycle.
- prescale=8, serial_data=0 only at edge 4 → sampled_bit=1 (glitch rejected). serial_data=0 at edges 3 and 5 → sampled_bit=0.
- prescale=16, line 0 for a whole bit → taps at 7,8,9. sample_valid 10 cycles after enable rises with sampled_bit=0, and bit_done every 16 cycles.
- prescale=8, enable dropped while edge_count=4 → edge_count=0 next cycle, and no sample_valid or bit_done for that bit.
- prescale=5 → prescale_error=1 after one cycle, edge_count stays 0, no pulses. prescale=8 → prescale_error=0 after one cycle and counting resumes.
- reset asserted at edge_count=5 (T2 capture cycle) → next cycle all outputs at reset values, and no sample_valid pulse.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared UART receiver constants and prescale helpers
package uart_rx_pkg;

  localparam int   DEFAULT_PRESCALE_WIDTH = 6;
  localparam logic UART_IDLE_LEVEL        = 1'b1;

  // Tap k (0..2) sits around mid-bit: prescale/2-1, prescale/2, prescale/2+1.
  function automatic int tap_index(input int prescale, input int k);
    return prescale / 2 - 1 + k;
  endfunction

  function automatic logic prescale_legal(input int prescale);
    return (prescale % 2 == 0) && (prescale >= 4);
  endfunction

endpackage

// File: rtl/uart_rx_majority3.sv
// rtl/uart_rx_majority3.sv - combinational 2-of-3 majority vote
module uart_rx_majority3 (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic y
);

  assign y = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/uart_rx_data_sampler.sv
// rtl/uart_rx_data_sampler.sv - oversampling mid-bit sampler with majority vote
// Optional input synchronizer enabled by defining DATA_SAMPLER_SYNC_EN.
module uart_rx_data_sampler
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_WIDTH = DEFAULT_PRESCALE_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      serial_data,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      sampled_bit,
  output logic                      sample_valid,
  output logic                      bit_done,
  output logic [PRESCALE_WIDTH-1:0] edge_count,
  output logic                      prescale_error
);

  logic line;

`ifdef DATA_SAMPLER_SYNC_EN
  logic sync_meta;
  logic sync_line;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_meta <= UART_IDLE_LEVEL;
      sync_line <= UART_IDLE_LEVEL;
    end else begin
      sync_meta <= serial_data;
      sync_line <= sync_meta;
    end
  end

  assign line = sync_line;
`else
  assign line = serial_data;
`endif

  logic                      legal;
  logic                      active;
  logic                      hit0;
  logic                      hit1;
  logic                      hit2;
  logic                      last_edge;
  logic                      vote;
  logic                      vote_c;
  logic                      s0;
  logic                      s1;
  logic                      s2;
  logic [PRESCALE_WIDTH-1:0] last_index;

  assign legal      = prescale_legal(int'(prescale));
  assign active     = enable && legal;
  assign last_index = prescale - PRESCALE_WIDTH'(1);
  assign hit0       = active && (int'(edge_count) == tap_index(int'(prescale), 0));
  assign hit1       = active && (int'(edge_count) == tap_index(int'(prescale), 1));
  assign hit2       = active && (int'(edge_count) == tap_index(int'(prescale), 2));
  assign last_edge  = active && (edge_count == last_index);

  // The vote is registered in the T2 cycle, so the third input is the live line.
  assign vote_c = hit2 ? line : s2;

  uart_rx_majority3 u_vote (
    .a (s0),
    .b (s1),
    .c (vote_c),
    .y (vote)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      edge_count     <= '0;
      s0             <= UART_IDLE_LEVEL;
      s1             <= UART_IDLE_LEVEL;
      s2             <= UART_IDLE_LEVEL;
      sampled_bit    <= UART_IDLE_LEVEL;
      sample_valid   <= 1'b0;
      bit_done       <= 1'b0;
      prescale_error <= 1'b0;
    end else begin
      prescale_error <= !legal;
      sample_valid   <= hit2;
      bit_done       <= last_edge;
      if (hit0) s0 <= line;
      if (hit1) s1 <= line;
      if (hit2) begin
        s2          <= line;
        sampled_bit <= vote;
      end
      // Also catches a count left beyond a newly shortened prescale.
      if (!active || edge_count >= last_index)
        edge_count <= '0;
      else
        edge_count <= edge_count + PRESCALE_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_uart_rx_data_sampler.sv
// tb/tb_uart_rx_data_sampler.sv - bench for uart_rx_data_sampler
module tb_uart_rx_data_sampler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       serial_data = 1'b1;
  logic [5:0] prescale = 6'd8;
  logic       sampled_bit;
  logic       sample_valid;
  logic       bit_done;
  logic [5:0] edge_count;
  logic       prescale_error;

  int checks = 0;
  int failures = 0;

  uart_rx_data_sampler #(.PRESCALE_WIDTH(6)) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .serial_data    (serial_data),
    .prescale       (prescale),
    .sampled_bit    (sampled_bit),
    .sample_valid   (sample_valid),
    .bit_done       (bit_done),
    .edge_count     (edge_count),
    .prescale_error (prescale_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: position within the bit, the three mid-bit line samples, vote by count.
  bit m_ready = 0;
  int m_cnt = 0;
  bit m_bit = 1, m_valid = 0, m_done = 0, m_err = 0;
  bit m_win[3] = '{1, 1, 1};
  bit m_d1 = 1, m_d2 = 1;

  always @(posedge clk) begin
    int p;
    int half;
    bit din;
`ifdef DATA_SAMPLER_SYNC_EN
    din = m_d2;
`else
    din = serial_data;
`endif
    if (reset) begin
      m_ready = 1;
      m_cnt = 0; m_bit = 1; m_valid = 0; m_done = 0; m_err = 0;
      m_win = '{1, 1, 1};
      m_d1 = 1; m_d2 = 1;
    end else begin
      p = int'(prescale);
      half = p / 2;
      m_err = !((p % 2 == 0) && (p >= 4));
      m_valid = 0;
      m_done = 0;
      if (enable && !m_err) begin
        if (m_cnt >= half - 1 && m_cnt <= half + 1) m_win[m_cnt - half + 1] = din;
        if (m_cnt == half + 1) begin
          m_valid = 1;
          m_bit = (int'(m_win[0]) + int'(m_win[1]) + int'(m_win[2])) >= 2;
        end
        if (m_cnt == p - 1) m_done = 1;
        m_cnt = (m_cnt + 1 >= p) ? 0 : m_cnt + 1;
      end else begin
        m_cnt = 0;
      end
      m_d2 = m_d1;
      m_d1 = serial_data;
    end
  end

  always @(negedge clk) begin
    if (m_ready) begin
      chk("model_edge_count", edge_count, m_cnt);
      chk("model_sampled_bit", sampled_bit, m_bit);
      chk("model_sample_valid", sample_valid, m_valid);
      chk("model_bit_done", bit_done, m_done);
      chk("model_prescale_error", prescale_error, m_err);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Drives one bit starting at edge_count 0; reports tick index of each pulse.
  task automatic drive_bit(input logic [15:0] pat, input int p,
                           output int valid_at, output logic bit_val, output int done_at);
    valid_at = -1; done_at = -1; bit_val = 1'bx;
    for (int e = 0; e < p; e++) begin
      serial_data = pat[e];
      tick();
      if (sample_valid) begin valid_at = e + 1; bit_val = sampled_bit; end
      if (bit_done) done_at = e + 1;
    end
  endtask

  initial begin
    int va, da, pulses, maxc;
    logic bv;

    repeat (3) tick();
    chk("rst_edge_count", edge_count, 0);
    chk("rst_sampled_bit", sampled_bit, 1);
    chk("rst_sample_valid", sample_valid, 0);
    chk("rst_bit_done", bit_done, 0);
    chk("rst_prescale_error", prescale_error, 0);

    reset = 0; enable = 1;
    drive_bit(16'hFFFF, 8, va, bv, da);
    chk("p8_ones_valid_at", va, 6);
    chk("p8_ones_bit", bv, 1);
    chk("p8_ones_done_at", da, 8);
    chk("p8_ones_wrap_count", edge_count, 0);

    drive_bit(16'hFFEF, 8, va, bv, da);
    chk("p8_glitch_bit", bv, 1);
    drive_bit(16'hFFD7, 8, va, bv, da);
    chk("p8_zero35_bit", bv, 0);

    prescale = 16;
    drive_bit(16'h0000, 16, va, bv, da);
    chk("p16_valid_at", va, 10);
    chk("p16_bit", bv, 0);
    chk("p16_done_at", da, 16);
    drive_bit(16'h0000, 16, va, bv, da);
    chk("p16_done_at_2", da, 16);

    prescale = 4;
    drive_bit(16'hFFFF, 4, va, bv, da);
    chk("p4_valid_at", va, 4);
    chk("p4_done_at", da, 4);
    chk("p4_bit", bv, 1);

    prescale = 8; serial_data = 0;
    repeat (4) tick();
    chk("en_drop_count_before", edge_count, 4);
    enable = 0;
    tick();
    chk("en_drop_count_after", edge_count, 0);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      if (sample_valid || bit_done) pulses++;
      tick();
    end
    chk("en_drop_pulses", pulses, 0);
    chk("en_drop_bit_held", sampled_bit, 1);

    enable = 1; prescale = 5;
    tick();
    chk("p5_error", prescale_error, 1);
    chk("p5_count", edge_count, 0);
    pulses = 0; maxc = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (sample_valid || bit_done) pulses++;
      if (int'(edge_count) > maxc) maxc = int'(edge_count);
    end
    chk("p5_pulses", pulses, 0);
    chk("p5_max_count", maxc, 0);
    prescale = 8;
    tick();
    chk("p8_error_clear", prescale_error, 0);
    chk("p8_resume_count", edge_count, 1);
    repeat (7) tick();
    chk("p8_resume_wrap", edge_count, 0);

    prescale = 16; serial_data = 0;
    repeat (12) tick();
    chk("mid_change_count", edge_count, 12);
    chk("mid_change_bit", sampled_bit, 0);
    prescale = 8;
    tick();
    chk("mid_change_wrap", edge_count, 0);
    chk("mid_change_no_done", bit_done, 0);

    repeat (5) tick();
    chk("rst_mid_count_before", edge_count, 5);
    reset = 1;
    tick();
    chk("rst_mid_count", edge_count, 0);
    chk("rst_mid_bit", sampled_bit, 1);
    chk("rst_mid_valid", sample_valid, 0);
    chk("rst_mid_done", bit_done, 0);
    reset = 0;
    tick();
    chk("rst_mid_no_pulse", sample_valid, 0);
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
